// File: rtl/control_fsm_p.sv
// Parametrised multi-cycle control unit: fetch, decode and sequence the downsampling datapath.
// Define CTRL_TRAP_EN to send illegal opcodes/indices to a TRAP state; otherwise they execute as NOP.
module control_fsm_p #(
    parameter int IW     = 16,
    parameter int NUM_GP = 6,
    localparam int SELW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IW-1:0]     instruction,
    input  logic              z,
    input  logic              n,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [SELW-1:0]   bus_sel,
    output logic              ld_ir,
    output logic              ld_pc,
    output logic              ld_ar,
    output logic              ld_ac,
    output logic              ld_alu,
    output logic [NUM_GP-1:0] ld_gp,
    output logic              inc_pc,
    output logic              inc_ac,
    output logic              inc_ar,
    output logic [NUM_GP-1:0] inc_gp,
    output logic              pc_clr,
    output logic [2:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              trap,
    output logic [3:0]        state_dbg
);

    localparam logic [5:0] OP_NOP     = 6'd0;
    localparam logic [5:0] OP_LOADAC  = 6'd1;
    localparam logic [5:0] OP_STAC    = 6'd2;
    localparam logic [5:0] OP_MOVACR  = 6'd3;
    localparam logic [5:0] OP_MOVRAC  = 6'd4;
    localparam logic [5:0] OP_ADD     = 6'd5;
    localparam logic [5:0] OP_SUB     = 6'd6;
    localparam logic [5:0] OP_LSH     = 6'd7;
    localparam logic [5:0] OP_RSH     = 6'd8;
    localparam logic [5:0] OP_INC     = 6'd9;
    localparam logic [5:0] OP_LOADIM  = 6'd10;
    localparam logic [5:0] OP_JUMP    = 6'd11;
    localparam logic [5:0] OP_JUMPZ   = 6'd12;
    localparam logic [5:0] OP_JUMPNZ  = 6'd13;
    localparam logic [5:0] OP_JUMPN   = 6'd14;
    localparam logic [5:0] OP_MOVACAR = 6'd15;
    localparam logic [5:0] OP_MOVARAC = 6'd16;
    localparam logic [5:0] OP_END     = 6'd63;

    localparam logic [SELW-1:0] SEL_AR = 4'd1;
    localparam logic [SELW-1:0] SEL_AC = 4'd2;
    localparam logic [SELW-1:0] SEL_IM = 4'd3;
    localparam logic [SELW-1:0] SEL_DM = 4'd4;
    localparam logic [SELW-1:0] SEL_R0 = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ALU_WB,
        S_LD_M,
        S_ST_M,
        S_OPRD,
        S_SKIP,
`ifdef CTRL_TRAP_EN
        S_TRAP,
`endif
        S_END
    } state_t;

    state_t state;

    logic [5:0]        op;
    logic [3:0]        ridx;
    logic              idx_ok;
    logic              illegal;
    logic              taken;
    logic [NUM_GP-1:0] gp_sel;
    logic [NUM_GP-1:0] gp_inc_sel;
    logic              unused_instr_bits;

    assign op                = instruction[5:0];
    assign ridx              = instruction[11:8];
    assign unused_instr_bits = ^instruction;
    assign state_dbg         = state;

    function automatic logic [2:0] alu_code(input logic [5:0] opc);
        case (opc)
            OP_ADD:  return 3'd1;
            OP_SUB:  return 3'd2;
            OP_LSH:  return 3'd3;
            OP_RSH:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // INC addresses AC and AR with r=0/1, so general registers start at r=2.
    always_comb begin
        gp_sel     = '0;
        gp_inc_sel = '0;
        for (int k = 0; k < NUM_GP; k++) begin
            gp_sel[k]     = (int'(ridx) == k);
            gp_inc_sel[k] = (int'(ridx) == k + 2);
        end
    end

    always_comb begin
        idx_ok  = 1'b1;
        illegal = 1'b0;
        taken   = 1'b1;
        case (op)
            OP_MOVACR, OP_MOVRAC: idx_ok = (int'(ridx) < NUM_GP);
            OP_INC:               idx_ok = (int'(ridx) < NUM_GP + 2);
            default:              idx_ok = 1'b1;
        endcase
        illegal = !((op <= OP_MOVARAC) || (op == OP_END)) || !idx_ok;
        case (op)
            OP_JUMPZ:  taken = z;
            OP_JUMPNZ: taken = !z;
            OP_JUMPN:  taken = n;
            default:   taken = 1'b1;
        endcase
    end

    // Memory handshake: mem_req stays high with every other output held stable until a
    // cycle with mem_ready=1; the access completes in that cycle and the FSM advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (illegal) begin
`ifdef CTRL_TRAP_EN
                        state <= S_TRAP;
`else
                        state <= S_FETCH;
`endif
                    end else begin
                        case (op)
                            OP_ADD, OP_SUB, OP_LSH, OP_RSH:  state <= S_ALU_WB;
                            OP_LOADAC:                       state <= S_LD_M;
                            OP_STAC:                         state <= S_ST_M;
                            OP_LOADIM, OP_JUMP:              state <= S_OPRD;
                            OP_JUMPZ, OP_JUMPNZ, OP_JUMPN:   state <= taken ? S_OPRD : S_SKIP;
                            OP_END:                          state <= S_END;
                            default:                         state <= S_FETCH;
                        endcase
                    end
                end
                S_ALU_WB: state <= S_FETCH;
                S_LD_M:   if (mem_ready) state <= S_FETCH;
                S_ST_M:   if (mem_ready) state <= S_FETCH;
                S_OPRD:   if (mem_ready) state <= S_FETCH;
                S_SKIP:   state <= S_FETCH;
                S_END:    if (start) state <= S_FETCH;
`ifdef CTRL_TRAP_EN
                S_TRAP:   if (start) state <= S_FETCH;
`endif
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        bus_sel = '0;
        ld_ir   = 1'b0;
        ld_pc   = 1'b0;
        ld_ar   = 1'b0;
        ld_ac   = 1'b0;
        ld_alu  = 1'b0;
        ld_gp   = '0;
        inc_pc  = 1'b0;
        inc_ac  = 1'b0;
        inc_ar  = 1'b0;
        inc_gp  = '0;
        pc_clr  = 1'b0;
        alu_op  = 3'd0;
        done    = 1'b0;
        trap    = 1'b0;
        case (state)
            S_IDLE: pc_clr = start && !rst;
            S_FETCH: begin
                mem_req = 1'b1;
                bus_sel = SEL_IM;
                ld_ir   = mem_ready;
            end
            S_DECODE: begin
                if (illegal) begin
`ifndef CTRL_TRAP_EN
                    inc_pc = 1'b1;
`endif
                end else begin
                    case (op)
                        OP_NOP: inc_pc = 1'b1;
                        OP_MOVACR: begin
                            bus_sel = SEL_AC;
                            ld_gp   = gp_sel;
                            inc_pc  = 1'b1;
                        end
                        OP_MOVRAC: begin
                            bus_sel = SEL_R0 + ridx;
                            ld_ac   = 1'b1;
                            inc_pc  = 1'b1;
                        end
                        OP_INC: begin
                            inc_ac = (ridx == 4'd0);
                            inc_ar = (ridx == 4'd1);
                            inc_gp = gp_inc_sel;
                            inc_pc = 1'b1;
                        end
                        OP_MOVACAR: begin
                            bus_sel = SEL_AC;
                            ld_ar   = 1'b1;
                            inc_pc  = 1'b1;
                        end
                        OP_MOVARAC: begin
                            bus_sel = SEL_AR;
                            ld_ac   = 1'b1;
                            inc_pc  = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_LSH, OP_RSH: alu_op = alu_code(op);
                        OP_LOADAC: begin
                            bus_sel = SEL_AC;
                            ld_ar   = 1'b1;
                        end
                        OP_LOADIM, OP_JUMP, OP_JUMPZ, OP_JUMPNZ, OP_JUMPN: inc_pc = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ALU_WB: begin
                alu_op = alu_code(op);
                ld_alu = 1'b1;
                inc_pc = 1'b1;
            end
            S_LD_M: begin
                mem_req = 1'b1;
                bus_sel = SEL_DM;
                ld_ac   = mem_ready;
                inc_pc  = mem_ready;
            end
            S_ST_M: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                bus_sel = SEL_AC;
                inc_pc  = mem_ready;
            end
            S_OPRD: begin
                mem_req = 1'b1;
                bus_sel = SEL_IM;
                if (op == OP_LOADIM) begin
                    ld_ac  = mem_ready;
                    inc_pc = mem_ready;
                end else begin
                    ld_pc  = mem_ready;
                end
            end
            S_SKIP: inc_pc = 1'b1;
            S_END: begin
                done   = 1'b1;
                pc_clr = start && !rst;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: begin
                trap   = 1'b1;
                pc_clr = start && !rst;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        busy = 1'b1;
        case (state)
            S_IDLE, S_END: busy = 1'b0;
`ifdef CTRL_TRAP_EN
            S_TRAP:        busy = 1'b0;
`endif
            default:       busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_control_fsm_p.sv
// Bench for control_fsm_p: random instruction stream, per-cycle expected outputs from an
// instruction-level model, checked by a queue-driven monitor on the falling edge.
module tb_control_fsm_p;
    localparam int IW     = 16;
    localparam int NUM_GP = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IW-1:0]     instruction;
    logic              z;
    logic              n;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        bus_sel;
    logic              ld_ir;
    logic              ld_pc;
    logic              ld_ar;
    logic              ld_ac;
    logic              ld_alu;
    logic [NUM_GP-1:0] ld_gp;
    logic              inc_pc;
    logic              inc_ac;
    logic              inc_ar;
    logic [NUM_GP-1:0] inc_gp;
    logic              pc_clr;
    logic [2:0]        alu_op;
    logic              busy;
    logic              done;
    logic              trap;
    logic [3:0]        state_dbg;

    typedef struct packed {
        logic              mem_req;
        logic              mem_we;
        logic [3:0]        bus_sel;
        logic              ld_ir;
        logic              ld_pc;
        logic              ld_ar;
        logic              ld_ac;
        logic              ld_alu;
        logic [NUM_GP-1:0] ld_gp;
        logic              inc_pc;
        logic              inc_ac;
        logic              inc_ar;
        logic [NUM_GP-1:0] inc_gp;
        logic              pc_clr;
        logic [2:0]        alu_op;
        logic              busy;
        logic              done;
        logic              trap;
    } out_t;

    localparam int OW = $bits(out_t);

    logic [OW-1:0] exp_q[$];
    string         tag_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    out_t          act;

    control_fsm_p #(.IW(IW), .NUM_GP(NUM_GP)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .z(z), .n(n), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .bus_sel(bus_sel),
        .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_ar(ld_ar), .ld_ac(ld_ac), .ld_alu(ld_alu),
        .ld_gp(ld_gp), .inc_pc(inc_pc), .inc_ac(inc_ac), .inc_ar(inc_ar), .inc_gp(inc_gp),
        .pc_clr(pc_clr), .alu_op(alu_op), .busy(busy), .done(done), .trap(trap),
        .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    assign act = out_t'({mem_req, mem_we, bus_sel, ld_ir, ld_pc, ld_ar, ld_ac, ld_alu, ld_gp,
                         inc_pc, inc_ac, inc_ar, inc_gp, pc_clr, alu_op, busy, done, trap});

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [OW-1:0] e;
            string         t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: actual %h required %h (t=%0t)", t, act, e, $time);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs for this cycle.
    task automatic cyc(input out_t e, input logic rdy, input logic st, input logic zz,
                       input logic nn, input string tag);
        mem_ready = rdy;
        start     = st;
        z         = zz;
        n         = nn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int wf);
        out_t e;
        e = '0;
        e.mem_req = 1'b1;
        e.bus_sel = 4'd3;
        e.busy    = 1'b1;
        repeat (wf) cyc(e, 1'b0, rb(), rb(), rb(), "fetch_wait");
        e.ld_ir = 1'b1;
        cyc(e, 1'b1, rb(), rb(), rb(), "fetch");
    endtask

    task automatic mem_access(input out_t w, input out_t r, input int wm, input string tag);
        repeat (wm) cyc(w, 1'b0, rb(), rb(), rb(), tag);
        cyc(r, 1'b1, rb(), rb(), rb(), tag);
    endtask

    // Instruction-level model: what the unit must do for one instruction, cycle by cycle.
    // halted: 0 keeps running, 1 stopped in END, 2 stopped in TRAP.
    task automatic exec(input logic [5:0] op, input logic [3:0] r, input logic zz, input logic nn,
                        input int wf, input int wm, output int halted);
        out_t e, w, rd;
        int   ri;
        bit   legal, tk;
        ri     = int'(r);
        halted = 0;
        instruction = {4'($urandom_range(0, 15)), r, 2'($urandom_range(0, 3)), op};
        fetch(wf);
        e = '0;
        e.busy = 1'b1;
        w = '0;
        w.busy = 1'b1;
        w.mem_req = 1'b1;
        legal = (op <= 6'd16) || (op == 6'd63);
        if (op == 6'd3 || op == 6'd4) legal = legal && (ri < NUM_GP);
        if (op == 6'd9) legal = legal && (ri < NUM_GP + 2);
        if (!legal) begin
`ifdef CTRL_TRAP_EN
            cyc(e, rb(), rb(), zz, nn, "illegal_dec");
            halted = 2;
`else
            e.inc_pc = 1'b1;
            cyc(e, rb(), rb(), zz, nn, "illegal_nop");
`endif
            return;
        end
        case (op)
            6'd0: begin
                e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "nop");
            end
            6'd3: begin
                e.bus_sel = 4'd2; e.ld_gp[ri] = 1'b1; e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "movacr");
            end
            6'd4: begin
                e.bus_sel = 4'(5 + ri); e.ld_ac = 1'b1; e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "movrac");
            end
            6'd9: begin
                if (ri == 0) e.inc_ac = 1'b1;
                else if (ri == 1) e.inc_ar = 1'b1;
                else e.inc_gp[ri-2] = 1'b1;
                e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "inc");
            end
            6'd15: begin
                e.bus_sel = 4'd2; e.ld_ar = 1'b1; e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "movacar");
            end
            6'd16: begin
                e.bus_sel = 4'd1; e.ld_ac = 1'b1; e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "movarac");
            end
            6'd5, 6'd6, 6'd7, 6'd8: begin
                e.alu_op = 3'(op - 6'd4);
                cyc(e, rb(), rb(), zz, nn, "alu_dec");
                e.ld_alu = 1'b1; e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), rb(), rb(), "alu_wb");
            end
            6'd1: begin
                e.bus_sel = 4'd2; e.ld_ar = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "loadac_dec");
                w.bus_sel = 4'd4;
                rd = w; rd.ld_ac = 1'b1; rd.inc_pc = 1'b1;
                mem_access(w, rd, wm, "ld_m");
            end
            6'd2: begin
                cyc(e, rb(), rb(), zz, nn, "stac_dec");
                w.mem_we = 1'b1; w.bus_sel = 4'd2;
                rd = w; rd.inc_pc = 1'b1;
                mem_access(w, rd, wm, "st_m");
            end
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14: begin
                tk = (op == 6'd10) || (op == 6'd11) || (op == 6'd12 && zz) ||
                     (op == 6'd13 && !zz) || (op == 6'd14 && nn);
                e.inc_pc = 1'b1;
                cyc(e, rb(), rb(), zz, nn, "jmp_dec");
                if (tk) begin
                    w.bus_sel = 4'd3;
                    rd = w;
                    if (op == 6'd10) begin
                        rd.ld_ac = 1'b1; rd.inc_pc = 1'b1;
                    end else begin
                        rd.ld_pc = 1'b1;
                    end
                    mem_access(w, rd, wm, "oprd");
                end else begin
                    cyc(e, rb(), rb(), rb(), rb(), "skip");
                end
            end
            6'd63: begin
                cyc(e, rb(), rb(), zz, nn, "end_dec");
                halted = 1;
            end
            default: ;
        endcase
    endtask

    // Sit in END/TRAP for k cycles, then restart with start.
    task automatic restart(input int kind, input int k);
        out_t e;
        e = '0;
        if (kind == 2) e.trap = 1'b1;
        else e.done = 1'b1;
        repeat (k) cyc(e, rb(), 1'b0, rb(), rb(), "halt_hold");
        e.pc_clr = 1'b1;
        cyc(e, rb(), 1'b1, rb(), rb(), "restart");
    endtask

    initial begin
        out_t        e, w;
        int          h;
        logic [5:0]  op_tbl [20];
        logic [5:0]  op;
        op_tbl = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                   6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd63, 6'd40, 6'd33};
        rst = 1'b1; start = 1'b0; z = 1'b0; n = 1'b0; mem_ready = 1'b0; instruction = '0;
        @(posedge clk);
        #1;
        e = '0;
        cyc(e, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        cyc(e, 1'b1, 1'b1, 1'b0, 1'b0, "rst_over_start");
        rst = 1'b0;
        cyc(e, rb(), 1'b0, rb(), rb(), "idle");
        e.pc_clr = 1'b1;
        cyc(e, rb(), 1'b1, rb(), rb(), "start");

        exec(6'd3, 4'd5, 1'b0, 1'b0, 0, 0, h);

        // reset in the middle of a waiting LD_M
        instruction = {4'd0, 4'd0, 2'd0, 6'd1};
        fetch(1);
        e = '0; e.busy = 1'b1; e.bus_sel = 4'd2; e.ld_ar = 1'b1;
        cyc(e, rb(), rb(), rb(), rb(), "loadac_dec");
        w = '0; w.busy = 1'b1; w.mem_req = 1'b1; w.bus_sel = 4'd4;
        cyc(w, 1'b0, rb(), rb(), rb(), "ld_m_wait");
        rst = 1'b1;
        cyc(w, 1'b0, rb(), rb(), rb(), "ld_m_rst_cycle");
        rst = 1'b0;
        e = '0;
        cyc(e, 1'b0, 1'b0, rb(), rb(), "after_rst");
        e.pc_clr = 1'b1;
        cyc(e, rb(), 1'b1, rb(), rb(), "restart_after_rst");

        exec(6'd1, 4'd0, 1'b0, 1'b0, 0, 3, h);
        exec(6'd12, 4'd0, 1'b1, 1'b0, 0, 0, h);
        exec(6'd12, 4'd0, 1'b0, 1'b0, 0, 0, h);
        exec(6'd13, 4'd0, 1'b0, 1'b1, 1, 1, h);
        exec(6'd14, 4'd0, 1'b0, 1'b1, 0, 2, h);
        exec(6'd14, 4'd0, 1'b1, 1'b0, 0, 0, h);
        exec(6'd40, 4'd0, 1'b0, 1'b0, 0, 0, h);
        if (h != 0) restart(h, 1);
        exec(6'd2, 4'd3, 1'b0, 1'b0, 2, 2, h);
        exec(6'd10, 4'd0, 1'b0, 1'b0, 0, 1, h);
        exec(6'd9, 4'd7, 1'b0, 1'b0, 0, 0, h);
        exec(6'd63, 4'd0, 1'b0, 1'b0, 0, 0, h);
        restart(h, 3);
        exec(6'd63, 4'd0, 1'b0, 1'b0, 0, 0, h);
        restart(h, 0);

        for (int i = 0; i < 300; i++) begin
            op = op_tbl[$urandom_range(0, 19)];
            exec(op, 4'($urandom_range(0, 9)), rb(), rb(),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)), h);
            if (h != 0) restart(h, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
